marmot_wb_sram_bridge: RTL

Wishbone-slave bridge that gives the Caravel management core read/write access to the 8-bank data SRAM. It lets firmware be preloaded and inspected while the Marmot core is held in reset. It sits between the core's RW0 port and the SRAM macros: it passes core traffic through in normal mode and takes over the macro pins in WB-own mode. It also drives the core's reset hold.

---
 rtl/marmot_wb_pkg.sv | 29 ++
 rtl/marmot_sram_bank_mux.sv | 50 +++++
 rtl/marmot_wb_sram_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/marmot_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : marmot_wb_pkg
// Description : Shared constants and types for the Wishbone-to-SRAM bridge:
//               address map offsets, CTRL bit positions and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package marmot_wb_pkg;

   localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;

   // Offsets relative to the bridge base address
   localparam logic [31:0] WINDOW_OFS  = 32'h0000_0000;
   localparam logic [31:0] WINDOW_SIZE = 32'h0000_4000;
   localparam logic [31:0] CTRL_OFS    = 32'h0000_8000;

   // CTRL register bit positions
   localparam int CTRL_OWN_BIT = 0;
   localparam int CTRL_ERR_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RDATA  = 2'd2,
      ST_ACK    = 2'd3
   } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/marmot_sram_bank_mux.sv
`default_nettype none
// ============================================================================
// Module      : marmot_sram_bank_mux
// Description : Splits a word address into bank / in-bank word, drives the
//               active-low per-bank chip selects, and returns the read data
//               of the bank remembered from the last enabled access.
// Revision    : 1.0 - initial release
// ============================================================================
module marmot_sram_bank_mux #(
   parameter int ADDR_W = 12,
   parameter int NBANKS = 8,
   parameter int DATA_W = 32,
   parameter int BANK_W = $clog2(NBANKS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [ADDR_W-1:0]              addr,
   input  logic [NBANKS-1:0][DATA_W-1:0]  rdata,
   output logic [NBANKS-1:0]              csb,
   output logic [ADDR_W-BANK_W-1:0]       word,
   output logic [DATA_W-1:0]              rdata_sel
);

   logic [BANK_W-1:0] bank;
   logic [BANK_W-1:0] bank_q;

   assign bank = addr[ADDR_W-1 -: BANK_W];
   assign word = addr[ADDR_W-BANK_W-1:0];

   // One-hot-low chip select for the addressed bank while enabled
   generate
      for (genvar i = 0; i < NBANKS; i++) begin : g_csb
         assign csb[i] = ~(en && (bank == BANK_W'(i)));
      end
   endgenerate

   // Remember which bank was accessed so its data can be picked next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= '0;
      end else if (en) begin
         bank_q <= bank;
      end
   end

   assign rdata_sel = rdata[bank_q];

endmodule
`default_nettype wire

// File: rtl/marmot_wb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : marmot_wb_sram_bridge
// Description : Wishbone slave giving the management core access to the
//               8-bank data SRAM. Core RW0 traffic passes through unless the
//               WB side owns the macros, in which case the core is held in
//               reset and the macro pins follow the latched WB request.
// Revision    : 1.0 - initial release
// ============================================================================
module marmot_wb_sram_bridge
   import marmot_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int          ADDR_W    = 12,
   parameter int          NBANKS    = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wbs_stb_i,
   input  logic                               wbs_cyc_i,
   input  logic                               wbs_we_i,
   input  logic [3:0]                         wbs_sel_i,
   input  logic [31:0]                        wbs_adr_i,
   input  logic [31:0]                        wbs_dat_i,
   output logic                               wbs_ack_o,
   output logic [31:0]                        wbs_dat_o,
   input  logic [ADDR_W-1:0]                  core_addr,
   input  logic                               core_en,
   input  logic                               core_wmode,
   input  logic [31:0]                        core_wdata,
   input  logic [3:0]                         core_wmask,
   output logic [31:0]                        core_rdata,
   output logic                               core_rst_n,
   output logic [ADDR_W-$clog2(NBANKS)-1:0]   ram_addr,
   output logic [31:0]                        ram_wdata,
   output logic [3:0]                         ram_wmask,
   output logic [NBANKS-1:0]                  ram_csb,
   output logic                               ram_web,
   input  logic [31:0]                        ram_rdata0,
   input  logic [31:0]                        ram_rdata1,
   input  logic [31:0]                        ram_rdata2,
   input  logic [31:0]                        ram_rdata3,
   input  logic [31:0]                        ram_rdata4,
   input  logic [31:0]                        ram_rdata5,
   input  logic [31:0]                        ram_rdata6,
   input  logic [31:0]                        ram_rdata7
);

   wb_state_e               state, state_nxt;
   logic                    req, win_hit, ctrl_hit;
   logic [31:0]             offset;
   logic [ADDR_W-1:0]       wadr_q;
   logic [31:0]             dat_q;
   logic                    we_q;
   logic [3:0]              sel_q;
   logic                    ctrl_q;
   logic                    own, err;
   logic                    wb_en;
   logic                    err_set, ctrl_wr;
   logic                    src_en;
   logic [ADDR_W-1:0]       src_addr;
   logic [31:0]             sel_rdata;
   logic [NBANKS-1:0][31:0] rdata_all;

   assign req      = wbs_stb_i & wbs_cyc_i;
   assign offset   = wbs_adr_i - BASE_ADDR;
   assign win_hit  = (offset - WINDOW_OFS) < WINDOW_SIZE;
   assign ctrl_hit = (offset == CTRL_OFS);

   // FSM state register; reset aborts any transaction without an ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, ack and WB-side macro enable
   always_comb begin
      state_nxt = state;
      wbs_ack_o = 1'b0;
      wb_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = (win_hit && own) ? ST_ACCESS : ST_ACK;
            end
         end
         ST_ACCESS: begin
            // A write with no bytes selected touches no macro
            wb_en = !(we_q && (sel_q == 4'b0000));
            if (!wbs_cyc_i) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = we_q ? ST_ACK : ST_RDATA;
            end
         end
         ST_RDATA: begin
            state_nxt = wbs_cyc_i ? ST_ACK : ST_IDLE;
         end
         ST_ACK: begin
            wbs_ack_o = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch and read-data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wadr_q    <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         ctrl_q    <= 1'b0;
         wbs_dat_o <= '0;
      end else if (state == ST_IDLE && req) begin
         wadr_q    <= offset[ADDR_W+1:2];
         dat_q     <= wbs_dat_i;
         we_q      <= wbs_we_i;
         sel_q     <= wbs_sel_i;
         ctrl_q    <= ctrl_hit;
         // CTRL reads return the register; everything else answers 0 here
         wbs_dat_o <= (ctrl_hit && !wbs_we_i) ? {30'd0, err, own} : 32'd0;
      end else if (state == ST_RDATA) begin
         wbs_dat_o <= sel_rdata;
      end
   end

   assign err_set = (state == ST_IDLE) && req && win_hit && !own;
   assign ctrl_wr = (state == ST_ACK) && ctrl_q && we_q;

   // CTRL register: own is plain RW, err is sticky with set priority over W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own <= 1'b0;
         err <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            own <= dat_q[CTRL_OWN_BIT];
         end
         if (err_set) begin
            err <= 1'b1;
         end else if (ctrl_wr && dat_q[CTRL_ERR_BIT]) begin
            err <= 1'b0;
         end
      end
   end

   assign src_en   = own ? wb_en  : core_en;
   assign src_addr = own ? wadr_q : core_addr;

   assign rdata_all = {ram_rdata7, ram_rdata6, ram_rdata5, ram_rdata4,
                       ram_rdata3, ram_rdata2, ram_rdata1, ram_rdata0};

   marmot_sram_bank_mux #(
      .ADDR_W (ADDR_W),
      .NBANKS (NBANKS),
      .DATA_W (32)
   ) u_bank_mux (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (src_en),
      .addr      (src_addr),
      .rdata     (rdata_all),
      .csb       (ram_csb),
      .word      (ram_addr),
      .rdata_sel (sel_rdata)
   );

   assign ram_wdata  = own ? dat_q : core_wdata;
   assign ram_wmask  = own ? sel_q : core_wmask;
   assign ram_web    = own ? ~(wb_en & we_q) : ~(core_en & core_wmode);
   assign core_rdata = own ? 32'd0 : sel_rdata;
   assign core_rst_n = ~own;

endmodule
`default_nettype wire
